// File: rtl/calc1_if.sv
// calc1_if: request/response bundle for the four calculator ports (MSB-first fields, declared descending)
interface calc1_if;
  logic [3:0]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [31:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [31:0] out_data1, out_data2, out_data3, out_data4;
  logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_data1, out_data2, out_data3, out_data4,
    input  out_resp1, out_resp2, out_resp3, out_resp4
  );
  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_data1, out_data2, out_data3, out_data4,
    output out_resp1, out_resp2, out_resp3, out_resp4
  );
endinterface

// File: rtl/calc1_unit.sv
// calc1_unit: four independent two-operand add/sub/shift engines with registered one-cycle responses
module calc1_unit (
  input logic    c_clk,
  input logic    reset,
  calc1_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OP2, RESP} state_t;
  logic [3:0]  w_cmd  [4];
  logic [31:0] w_data [4];
  assign w_cmd[0]  = bus.req1_cmd_in;
  assign w_cmd[1]  = bus.req2_cmd_in;
  assign w_cmd[2]  = bus.req3_cmd_in;
  assign w_cmd[3]  = bus.req4_cmd_in;
  assign w_data[0] = bus.req1_data_in;
  assign w_data[1] = bus.req2_data_in;
  assign w_data[2] = bus.req3_data_in;
  assign w_data[3] = bus.req4_data_in;
  // returns {resp, data}; errors always carry zero data
  function automatic logic [33:0] calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return c == 4'd1 ? (s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]}) :
           c == 4'd2 ? (b > a ? {2'd2, 32'd0} : {2'd1, a - b}) :
           c == 4'd5 ? {2'd1, a << b[4:0]} :
           c == 4'd6 ? {2'd1, a >> b[4:0]} : {2'd2, 32'd0};
  endfunction
  for (genvar i = 0; i < 4; i++) begin : g_eng
    state_t      r_state;
    logic [3:0]  r_cmd;
    logic [31:0] r_op1;
    logic [1:0]  r_resp;
    logic [31:0] r_data;
    // engine: latch cmd/op1, then op2 and result; response lives one cycle and a new command may start as it ends
    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        r_state <= IDLE;
        r_cmd   <= '0;
        r_op1   <= '0;
        r_resp  <= '0;
        r_data  <= '0;
      end else begin
        r_resp <= '0;
        r_data <= '0;
        case (r_state)
          OP2: begin
            {r_resp, r_data} <= calc(r_cmd, r_op1, w_data[i]);
            r_state <= RESP;
          end
          default: begin
            r_cmd   <= w_cmd[i];
            r_op1   <= w_data[i];
            r_state <= w_cmd[i] != 4'd0 ? OP2 : IDLE;
          end
        endcase
      end
    end
  end
  assign bus.out_resp1 = g_eng[0].r_resp;
  assign bus.out_resp2 = g_eng[1].r_resp;
  assign bus.out_resp3 = g_eng[2].r_resp;
  assign bus.out_resp4 = g_eng[3].r_resp;
  assign bus.out_data1 = g_eng[0].r_data;
  assign bus.out_data2 = g_eng[1].r_data;
  assign bus.out_data3 = g_eng[2].r_data;
  assign bus.out_data4 = g_eng[3].r_data;
endmodule

// File: tb/tb_calc1_unit.sv
// tb_calc1_unit: directed tests for the four-port calculator
module tb_calc1_unit;
  logic c_clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  calc1_if ifc ();
  calc1_unit dut (.c_clk(c_clk), .reset(reset), .bus(ifc));
  always #5 c_clk = ~c_clk;

  function automatic logic [33:0] obs(input int p);
    case (p)
      1: return {ifc.out_resp1, ifc.out_data1};
      2: return {ifc.out_resp2, ifc.out_data2};
      3: return {ifc.out_resp3, ifc.out_data3};
      default: return {ifc.out_resp4, ifc.out_data4};
    endcase
  endfunction

  task automatic set(input int p, input logic [3:0] c, input logic [31:0] d);
    case (p)
      1: begin ifc.req1_cmd_in = c; ifc.req1_data_in = d; end
      2: begin ifc.req2_cmd_in = c; ifc.req2_data_in = d; end
      3: begin ifc.req3_cmd_in = c; ifc.req3_data_in = d; end
      default: begin ifc.req4_cmd_in = c; ifc.req4_data_in = d; end
    endcase
  endtask

  // called at a negedge; returns at the negedge inside the RESP cycle
  task automatic do_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    set(p, c, a);
    @(negedge c_clk);
    set(p, 4'd0, b);
    @(negedge c_clk);
  endtask

  task automatic test_reset;
    logic [33:0] got;
    for (int p = 1; p <= 4; p++) set(p, 4'd0, 32'd0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge c_clk);
      for (int p = 1; p <= 4; p++) begin
        got = obs(p);
        n_cmp++;
        if (got !== 34'd0) begin n_fail++; $display("FAIL reset_during p%0d: got %h want 0", p, got); end
      end
    end
    reset = 1'b1;
    @(negedge c_clk);
    for (int p = 1; p <= 4; p++) begin
      got = obs(p);
      n_cmp++;
      if (got !== 34'd0) begin n_fail++; $display("FAIL reset_after p%0d: got %h want 0", p, got); end
    end
  endtask

  task automatic test_arith;
    logic [3:0]  c [12] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd6};
    logic [31:0] a [12] = '{32'h1, 32'h1FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd15, 32'hFFFF_FFFF,
                            32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [12] = '{32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h0, 32'h1, 32'd15, 32'd1, 32'h0,
                            32'h1234_5678, 32'h0, 32'd31, 32'h8000_0000, 32'd32};
    logic [33:0] e [12] = '{{2'd1, 32'h2000_0000}, {2'd1, 32'h3FFF_FFFE}, {2'd1, 32'h0}, {2'd2, 32'h0},
                            {2'd2, 32'h0}, {2'd1, 32'd14}, {2'd1, 32'hFFFF_FFFF}, {2'd1, 32'h0},
                            {2'd1, 32'h1234_5678}, {2'd1, 32'h1}, {2'd2, 32'h0}, {2'd1, 32'h8000_0000}};
    logic [33:0] got;
    @(negedge c_clk);
    for (int i = 0; i < 12; i++) begin
      do_op(1, c[i], a[i], b[i]);
      got = obs(1);
      n_cmp++;
      if (got !== e[i]) begin n_fail++; $display("FAIL arith[%0d]: got %h want %h", i, got, e[i]); end
      @(negedge c_clk);
      got = obs(1);
      n_cmp++;
      if (got !== 34'd0) begin n_fail++; $display("FAIL arith_clear[%0d]: got %h want 0", i, got); end
    end
  endtask

  task automatic test_invalid;
    logic [33:0] got;
    for (int c = 3; c <= 4; c++) begin
      set(1, 4'(c), 32'd1);
      @(negedge c_clk);
      set(1, 4'd0, 32'd1);
      got = obs(1);
      n_cmp++;
      if (got !== 34'd0) begin n_fail++; $display("FAIL invalid_op2 cmd%0d: got %h want 0", c, got); end
      @(negedge c_clk);
      got = obs(1);
      n_cmp++;
      if (got !== {2'd2, 32'd0}) begin n_fail++; $display("FAIL invalid cmd%0d: got %h want %h", c, got, {2'd2, 32'd0}); end
      @(negedge c_clk);
    end
  endtask

  task automatic test_walking;
    logic [33:0] got, exp;
    for (int k = 0; k <= 30; k++) begin
      do_op(1, 4'd1, 32'd1 << k, 32'd0);
      got = obs(1);
      exp = {2'd1, 32'd1 << k};
      n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL walk_add k=%0d: got %h want %h", k, got, exp); end
    end
    for (int k = 0; k <= 29; k++) begin
      do_op(1, 4'd5, 32'd1 << k, 32'd1);
      got = obs(1);
      exp = {2'd1, 32'd1 << (k + 1)};
      n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL walk_shl k=%0d: got %h want %h", k, got, exp); end
    end
    set(1, 4'd0, 32'd0);
    @(negedge c_clk);
  endtask

  task automatic test_parallel;
    logic [33:0] got;
    logic [33:0] e [4] = '{{2'd1, 32'd7}, {2'd1, 32'd99}, {2'd1, 32'h30}, {2'd1, 32'hF}};
    set(1, 4'd1, 32'd3);
    set(2, 4'd2, 32'd100);
    set(3, 4'd5, 32'h3);
    set(4, 4'd6, 32'hF0);
    @(negedge c_clk);
    set(1, 4'd0, 32'd4);
    set(2, 4'd0, 32'd1);
    set(3, 4'd0, 32'd4);
    set(4, 4'd0, 32'd4);
    @(negedge c_clk);
    for (int p = 1; p <= 4; p++) begin
      got = obs(p);
      n_cmp++;
      if (got !== e[p-1]) begin n_fail++; $display("FAIL parallel p%0d: got %h want %h", p, got, e[p-1]); end
    end
    @(negedge c_clk);
  endtask

  task automatic test_back_to_back;
    logic [33:0] got;
    do_op(2, 4'd1, 32'd10, 32'd20);
    got = obs(2);
    n_cmp++;
    if (got !== {2'd1, 32'd30}) begin n_fail++; $display("FAIL b2b_first: got %h want %h", got, {2'd1, 32'd30}); end
    do_op(2, 4'd2, 32'd50, 32'd8);
    got = obs(2);
    n_cmp++;
    if (got !== {2'd1, 32'd42}) begin n_fail++; $display("FAIL b2b_second: got %h want %h", got, {2'd1, 32'd42}); end
    set(2, 4'd0, 32'd0);
    @(negedge c_clk);
  endtask

  task automatic test_reset_in_op2;
    logic [33:0] got;
    set(3, 4'd1, 32'd5);
    @(negedge c_clk);
    set(3, 4'd0, 32'd6);
    #2 reset = 1'b0;
    @(negedge c_clk);
    got = obs(3);
    n_cmp++;
    if (got !== 34'd0) begin n_fail++; $display("FAIL rst_op2_during: got %h want 0", got); end
    reset = 1'b1;
    repeat (2) begin
      @(negedge c_clk);
      got = obs(3);
      n_cmp++;
      if (got !== 34'd0) begin n_fail++; $display("FAIL rst_op2_after: got %h want 0", got); end
    end
    do_op(3, 4'd1, 32'd5, 32'd6);
    got = obs(3);
    n_cmp++;
    if (got !== {2'd1, 32'd11}) begin n_fail++; $display("FAIL rst_op2_recover: got %h want %h", got, {2'd1, 32'd11}); end
    set(3, 4'd0, 32'd0);
    @(negedge c_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_invalid();
    test_walking();
    test_parallel();
    test_back_to_back();
    test_reset_in_op2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
